// File: rtl/vending_pkg.sv
// vending_pkg: shared definitions for the change dispenser.
//   sel_e       - hopper denomination codes (same encoding on disp_sel/refill_sel)
//   state_e     - dispenser FSM states
//   coin_value  - face value of a denomination code (0 for SEL_NONE)
package vending_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_1    = 2'b01,
        SEL_2    = 2'b10,
        SEL_5    = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        REQ    = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic [2:0] coin_value(input logic [1:0] sel);
        case (sel)
            SEL_1:   return 3'd1;
            SEL_2:   return 3'd2;
            SEL_5:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// change_dispense_ctrl_if: bundle between the vending FSM / hopper side and the
// change dispenser.
//   start/amount                 - transaction request
//   disp_req/disp_sel/disp_ack   - per-coin hopper handshake
//   refill_en/sel/cnt            - inventory top-up
//   busy/done/short/fault/remaining/cnt*/inv* - status
// modport slave is the dispenser, master is whoever drives it.
interface change_dispense_ctrl_if #(
    parameter int AMT_W = 7,
    parameter int INV_W = 6,
    parameter int CNT_W = 5
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             disp_req;
    logic [1:0]       disp_sel;
    logic             disp_ack;
    logic             refill_en;
    logic [1:0]       refill_sel;
    logic [INV_W-1:0] refill_cnt;
    logic             busy;
    logic             done;
    logic             short;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] cnt1, cnt2, cnt5;
    logic [INV_W-1:0] inv1, inv2, inv5;

    modport slave (
        input  start, amount, disp_ack, refill_en, refill_sel, refill_cnt,
        output disp_req, disp_sel, busy, done, short, fault, remaining,
               cnt1, cnt2, cnt5, inv1, inv2, inv5
    );

    modport master (
        output start, amount, disp_ack, refill_en, refill_sel, refill_cnt,
        input  disp_req, disp_sel, busy, done, short, fault, remaining,
               cnt1, cnt2, cnt5, inv1, inv2, inv5
    );
endinterface

// File: rtl/change_dispense_ctrl_inv_counter.sv
// inv_counter: coin inventory for one denomination.
//   clk, rst  - clock, async active-low reset (reloads INV_INIT)
//   add_en    - add add_cnt this cycle
//   add_cnt   - coins refilled
//   dec       - one coin left the hopper this cycle
//   inv       - current inventory
// Refill and dispense in the same cycle net out; the result saturates at the
// counter maximum.
module inv_counter #(
    parameter int INV_W    = 6,
    parameter int INV_INIT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en,
    input  logic [INV_W-1:0] add_cnt,
    input  logic             dec,
    output logic [INV_W-1:0] inv
);
    localparam logic [INV_W:0] INV_MAX = {1'b0, {INV_W{1'b1}}};

    logic [INV_W:0] sum;

    always_comb begin
        sum = {1'b0, inv} + (add_en ? {1'b0, add_cnt} : '0);
        // never below zero, even on a stray decrement of an empty bin
        if (dec && sum != '0) sum = sum - 1'b1;
        if (sum > INV_MAX)    sum = INV_MAX;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inv <= INV_W'(INV_INIT);
        else      inv <= sum[INV_W-1:0];
    end
endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: pays out a change amount one coin at a time, greedy
// 5/2/1 limited by inventory, with an ack timeout per coin.
//   clk, rst  - clock, async active-low reset (aborts any transaction)
//   bus       - change_dispense_ctrl_if.slave (request, hopper handshake,
//               refill, status and inventory outputs)
// All outputs are registered except disp_req, which decodes state == REQ so
// it drops the moment reset asserts.
module change_dispense_ctrl
    import vending_pkg::*;
#(
    parameter int AMT_W    = 7,
    parameter int INV_W    = 6,
    parameter int CNT_W    = 5,
    parameter int INV_INIT = 10,
    parameter int ACK_TO   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    change_dispense_ctrl_if.slave bus
);
    localparam int TO_W = $clog2(ACK_TO + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                     state, state_nxt;
    sel_e                       sel_pick;
    logic [1:0]                 disp_sel;
    logic [TO_W-1:0]            tmo;
    logic                       busy, done, short_q, fault;
    logic [AMT_W-1:0]           remaining;
    logic [CNT_W-1:0]           cnt1, cnt2, cnt5;
    logic [2:0][INV_W-1:0]      inv;    // [0]=1-coin, [1]=2-coin, [2]=5-coin
    logic                       ack_ok, tmo_hit;

    assign ack_ok  = (state == REQ) && bus.disp_ack;
    // tmo counts completed REQ cycles, so ACK_TO-1 marks the last one; an ack
    // in that cycle takes priority
    assign tmo_hit = (state == REQ) && !bus.disp_ack && (tmo == TO_W'(ACK_TO - 1));

    // denomination index gi maps to code gi+1 (01, 10, 11)
    for (genvar gi = 0; gi < 3; gi++) begin : g_inv
        localparam logic [1:0] CODE = 2'(gi + 1);
        inv_counter #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv (
            .clk     (clk),
            .rst     (rst),
            .add_en  (bus.refill_en && bus.refill_sel == CODE),
            .add_cnt (bus.refill_cnt),
            .dec     (ack_ok && disp_sel == CODE),
            .inv     (inv[gi])
        );
    end

    always_comb begin
        state_nxt = state;
        sel_pick  = SEL_NONE;
        unique case (state)
            IDLE:   if (bus.start) state_nxt = SELECT;
            SELECT: begin
                if (remaining == '0)                                  state_nxt = DONE;
                else if (remaining >= AMT_W'(5) && inv[2] != '0)      sel_pick  = SEL_5;
                else if (remaining >= AMT_W'(2) && inv[1] != '0)      sel_pick  = SEL_2;
                else if (inv[0] != '0)                                sel_pick  = SEL_1;
                else                                                  state_nxt = DONE;
                if (sel_pick != SEL_NONE) state_nxt = REQ;
            end
            REQ: begin
                if (ack_ok)       state_nxt = SELECT;
                else if (tmo_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            short_q   <= 1'b0;
            fault     <= 1'b0;
            remaining <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
            cnt5      <= '0;
            disp_sel  <= SEL_NONE;
            tmo       <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);   // DONE always lasts one cycle
            tmo  <= (state == REQ) ? tmo + 1'b1 : '0;

            if (state == SELECT)        disp_sel <= sel_pick;
            else if (state_nxt != REQ)  disp_sel <= SEL_NONE;

            case (state)
                IDLE: if (bus.start) begin
                    remaining <= bus.amount;
                    cnt1      <= '0;
                    cnt2      <= '0;
                    cnt5      <= '0;
                    short_q   <= 1'b0;
                    fault     <= 1'b0;
                end
                SELECT: if (remaining != '0 && sel_pick == SEL_NONE) short_q <= 1'b1;
                REQ: begin
                    if (ack_ok) begin
                        remaining <= remaining - AMT_W'(coin_value(disp_sel));
                        case (disp_sel)
                            SEL_1:   if (cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
                            SEL_2:   if (cnt2 != CNT_MAX) cnt2 <= cnt2 + 1'b1;
                            SEL_5:   if (cnt5 != CNT_MAX) cnt5 <= cnt5 + 1'b1;
                            default: ;
                        endcase
                    end else if (tmo_hit) begin
                        fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.disp_req  = (state == REQ);
    assign bus.disp_sel  = disp_sel;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.short     = short_q;
    assign bus.fault     = fault;
    assign bus.remaining = remaining;
    assign bus.cnt1      = cnt1;
    assign bus.cnt2      = cnt2;
    assign bus.cnt5      = cnt5;
    assign bus.inv1      = inv[0];
    assign bus.inv2      = inv[1];
    assign bus.inv5      = inv[2];
endmodule
